fir_symbol_slicer: RTL and testbench
====================================

FIR_SYMBOL_SLICER -- requirements
Module: fir_symbol_slicer

Interface
REQ-001 SHALL have parameter SPS, default 4: FIR output samples per symbol (2..16).
REQ-002 SHALL have parameter PHASE, default 0: decimation phase within a symbol (0..SPS-1).
REQ-003 SHALL have parameter SKIP, default 12: enable pulses discarded after start, covering FIR group delay plus register latency.
REQ-004 SHALL have parameter SHIFT, default 9: arithmetic right-shift applied before slicing.
REQ-005 SHALL have parameter DEPTH, default 4: output FIFO entries, a power of 2.
REQ-006 SHALL have port iClk_12MHz, input, 1, the single clock.
REQ-007 SHALL have port iRsn, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port iEnSample_600kHz, input, 1: one-cycle strobe qualifying iFirOut.
REQ-009 SHALL have port iFirOut, input, 16, signed filtered sample.
REQ-010 SHALL have port iSlicerEn, input, 1, level: run when 1.
REQ-011 SHALL have port oSymbol, output, 3, signed recovered symbol in -4..3 (FIFO head).
REQ-012 SHALL have port oSymValid, output, 1, FIFO not empty.
REQ-013 SHALL have port iSymReady, input, 1: consumer accepts oSymbol when oSymValid and iSymReady are both 1.
REQ-014 SHALL have port oOverflow, output, 1: sticky, symbol dropped on full FIFO.
REQ-015 SHALL have port oBusy, output, 1: state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> FLUSH -> RUN; any state -> IDLE on the edge where iSlicerEn=0.
REQ-017 SHALL move IDLE -> FLUSH on the first edge with iSlicerEn=1, clearing the skip counter and phase counter.
REQ-018 SHALL, in FLUSH, count iEnSample_600kHz pulses, and SHALL enter RUN on the edge of the SKIP-th pulse, discarding that sample; SKIP=0 goes directly to RUN.
REQ-019 SHALL, in RUN, advance the phase counter 0..SPS-1 with wrap on each strobe, and SHALL capture iFirOut when phase==PHASE at that strobe; the first RUN strobe has phase 0.
REQ-020 SHALL slice combinationally: 17-bit sign-extended iFirOut + 2^(SHIFT-1), arithmetic shift right SHIFT, saturate to [-4,3].
REQ-021 SHALL push the sliced symbol into the FIFO on the capture edge; oSymValid rises the next cycle if the FIFO was empty.
REQ-022 SHALL pop one entry per edge with oSymValid=1 and iSymReady=1, and SHALL hold oSymbol stable while oSymValid=1 and iSymReady=0.
REQ-023 SHALL accept a push on full with simultaneous pop, with no overflow; push on full without pop SHALL drop the new symbol and set oOverflow.
REQ-024 SHALL clear oOverflow only by reset or an IDLE -> FLUSH transition.
REQ-025 SHALL leave FIFO contents drainable in IDLE; entering FLUSH SHALL NOT clear them.
REQ-026 SHALL ignore iEnSample_600kHz in IDLE; a strobe on the edge leaving IDLE SHALL NOT count.

Reset
REQ-027 SHALL, with iRsn=0 at an edge, set state IDLE, counters 0, FIFO empty, oSymbol=0, oSymValid=0, oOverflow=0, oBusy=0; reset dominates all inputs.
REQ-028 SHALL, on reset mid-RUN, discard all FIFO contents; after release, restart only via iSlicerEn.

Structure
REQ-029 SHALL place symbol limits SYM_MIN=-4/SYM_MAX=3, FSM state encoding and parameter defaults in shared package fir_pkg.
REQ-030 SHALL implement the FIFO as sub-module sym_fifo (DEPTH, width 3, synchronous, active-low sync reset).

Verification
REQ-031 SHALL cover: iSlicerEn=1, strobe every 20 cycles, iFirOut=1000 constant -> first symbol after 13th strobe = 2, then every 4th strobe.
REQ-032 SHALL cover: iFirOut=16'h7FFF -> 3; iFirOut=-3000 -> -4; iFirOut=-700 -> -1; iFirOut=255 -> 0; iFirOut=256 -> 1.
REQ-033 SHALL cover: iSymReady=0, 5 symbols produced -> 4 held in order, oOverflow=1, 5th lost; then iSymReady=1 drains 4 then oSymValid=0.
REQ-034 SHALL cover: FIFO full, push and pop on the same edge -> count stays 4, oOverflow stays 0.
REQ-035 SHALL cover: iSlicerEn dropped mid-RUN -> oBusy=0 next cycle, queued symbols still drain; re-enable -> 12 strobes skipped again.
REQ-036 SHALL cover: iRsn=0 for one edge mid-RUN with 3 queued -> oSymValid=0, oSymbol=0, oOverflow=0 next cycle.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR symbol slicer: symbol limits, FSM encoding,
// parameter defaults and the saturating slice helper.
package fir_pkg;

    localparam int SYM_W     = 3;
    localparam int SYM_MIN   = -4;
    localparam int SYM_MAX   = 3;

    localparam int SPS_DEF   = 4;
    localparam int PHASE_DEF = 0;
    localparam int SKIP_DEF  = 12;
    localparam int SHIFT_DEF = 9;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic logic [SYM_W-1:0] sat_sym(input logic signed [16:0] v);
        if (v < SYM_MIN)
            return SYM_W'(SYM_MIN);
        else if (v > SYM_MAX)
            return SYM_W'(SYM_MAX);
        else
            return v[SYM_W-1:0];
    endfunction

endpackage

// File: rtl/sym_fifo.sv
// Small synchronous FIFO holding sliced symbols; head is forced to zero when empty.
module sym_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rsn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);

    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_valid = (r_cnt != '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_data  = o_valid ? r_mem[r_rd] : '0;

    // A pop on the same edge frees the slot, so a push on full is still accepted.
    assign w_pop  = i_pop && o_valid;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/fir_symbol_slicer.sv
// Decimates FIR output to one sample per symbol after a start-up flush,
// slices it to a 3-bit signed symbol and queues it for the consumer.
module fir_symbol_slicer
    import fir_pkg::*;
#(
    parameter int SPS   = SPS_DEF,
    parameter int PHASE = PHASE_DEF,
    parameter int SKIP  = SKIP_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              iClk_12MHz,
    input  logic              iRsn,
    input  logic              iEnSample_600kHz,
    input  logic signed [15:0] iFirOut,
    input  logic              iSlicerEn,
    output logic signed [2:0] oSymbol,
    output logic              oSymValid,
    input  logic              iSymReady,
    output logic              oOverflow,
    output logic              oBusy
);

    localparam int PW  = $clog2(SPS);
    localparam int SKW = (SKIP < 2) ? 1 : $clog2(SKIP + 1);
    localparam logic signed [16:0] ROUND = 17'sd1 <<< (SHIFT - 1);

    state_t                r_state;
    state_t                w_next;
    logic [SKW-1:0]        r_skip;
    logic [PW-1:0]         r_phase;
    logic                  r_ovf;
    logic signed [16:0]    w_ext;
    logic signed [16:0]    w_sum;
    logic signed [16:0]    w_shr;
    logic [SYM_W-1:0]      w_sym;
    logic [SYM_W-1:0]      w_head;
    logic                  w_start;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;

    assign w_ext = {iFirOut[15], iFirOut};
    assign w_sum = w_ext + ROUND;
    assign w_shr = w_sum >>> SHIFT;
    assign w_sym = sat_sym(w_shr);

    always_ff @(posedge iClk_12MHz) begin
        if (!iRsn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_push  = 1'b0;
        if (!iSlicerEn) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_start = 1'b1;
                    w_next  = (SKIP == 0) ? ST_RUN : ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (iEnSample_600kHz && r_skip == SKW'(SKIP - 1))
                        w_next = ST_RUN;
                end
                ST_RUN: begin
                    w_push = iEnSample_600kHz && (r_phase == PW'(PHASE));
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Counters restart on every IDLE exit; the overflow flag restarts with them.
    always_ff @(posedge iClk_12MHz) begin
        if (!iRsn) begin
            r_skip  <= '0;
            r_phase <= '0;
            r_ovf   <= 1'b0;
        end else if (w_start) begin
            r_skip  <= '0;
            r_phase <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == ST_FLUSH && iEnSample_600kHz)
                r_skip <= r_skip + 1'b1;
            if (r_state == ST_RUN && iEnSample_600kHz)
                r_phase <= (r_phase == PW'(SPS - 1)) ? '0 : r_phase + 1'b1;
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end

    assign w_pop = oSymValid && iSymReady;

    sym_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SYM_W)
    ) u_fifo (
        .i_clk   (iClk_12MHz),
        .i_rsn   (iRsn),
        .i_push  (w_push),
        .i_data  (w_sym),
        .i_pop   (iSymReady),
        .o_data  (w_head),
        .o_valid (oSymValid),
        .o_full  (w_full)
    );

    assign oSymbol   = w_head;
    assign oOverflow = r_ovf;
    assign oBusy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fir_symbol_slicer.sv
// Directed bench for fir_symbol_slicer with hand-computed symbol values.
module tb_fir_symbol_slicer;

    logic              clk;
    logic              iRsn;
    logic              iEn;
    logic signed [15:0] iFirOut;
    logic              iSlicerEn;
    logic signed [2:0] oSymbol;
    logic              oSymValid;
    logic              iSymReady;
    logic              oOverflow;
    logic              oBusy;

    int n_tests = 0;
    int n_fail  = 0;

    int vin  [6] = '{1000, 32767, -3000, -700, 255, 256};
    int vexp [6] = '{2, 3, -4, -1, 0, 1};
    int oin  [5] = '{1000, 32767, -3000, -700, 256};
    int oexp [5] = '{2, 3, -4, -1, 1};

    fir_symbol_slicer dut (
        .iClk_12MHz       (clk),
        .iRsn             (iRsn),
        .iEnSample_600kHz (iEn),
        .iFirOut          (iFirOut),
        .iSlicerEn        (iSlicerEn),
        .oSymbol          (oSymbol),
        .oSymValid        (oSymValid),
        .iSymReady        (iSymReady),
        .oOverflow        (oOverflow),
        .oBusy            (oBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int v);
        iFirOut = 16'(v);
        iEn     = 1'b1;
        @(negedge clk);
        iEn     = 1'b0;
        repeat (19) @(negedge clk);
    endtask

    task automatic filler();
        repeat (3) strobe(-3000);
    endtask

    task automatic pop1();
        iSymReady = 1'b1;
        @(negedge clk);
        iSymReady = 1'b0;
    endtask

    initial begin
        iRsn = 1'b0; iEn = 1'b0; iFirOut = '0; iSlicerEn = 1'b0; iSymReady = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", oSymValid, 0);
        check("rst_sym",   oSymbol,   0);
        check("rst_ovf",   oOverflow, 0);
        check("rst_busy",  oBusy,     0);

        iRsn = 1'b1;
        @(negedge clk);
        check("idle_busy", oBusy, 0);
        iSlicerEn = 1'b1;
        @(negedge clk);
        check("start_busy", oBusy, 1);

        repeat (12) strobe(1000);
        check("skip12_valid", oSymValid, 0);

        for (int i = 0; i < 6; i++) begin
            strobe(vin[i]);
            check("slice_valid", oSymValid, 1);
            check($sformatf("slice_%0d", vin[i]), oSymbol, vexp[i]);
            pop1();
            check("slice_popped", oSymValid, 0);
            filler();
            check("nocapture", oSymValid, 0);
        end

        for (int i = 0; i < 5; i++) begin
            strobe(oin[i]);
            filler();
            if (i == 3) check("full_no_ovf", oOverflow, 0);
        end
        check("ovf_set", oOverflow, 1);
        check("hold_a", oSymbol, 2);
        @(negedge clk);
        check("hold_b", oSymbol, 2);
        iSymReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", oSymValid, 1);
            check($sformatf("drain_%0d", i), oSymbol, oexp[i]);
            @(negedge clk);
        end
        iSymReady = 1'b0;
        check("drain_empty", oSymValid, 0);

        strobe(1000);  filler();
        strobe(-700);  filler();
        iSlicerEn = 1'b0;
        @(negedge clk);
        check("dis_busy", oBusy, 0);
        check("dis_ovf_sticky", oOverflow, 1);
        strobe(32767);
        check("idle_head", oSymbol, 2);
        pop1();
        check("idle_drain", oSymbol, -1);
        iSlicerEn = 1'b1;
        @(negedge clk);
        check("reen_busy", oBusy, 1);
        check("reen_ovf_clr", oOverflow, 0);
        check("reen_kept", oSymbol, -1);
        pop1();
        check("reen_empty", oSymValid, 0);
        repeat (12) strobe(1000);
        check("reskip_valid", oSymValid, 0);

        for (int i = 0; i < 4; i++) begin
            strobe(oin[i]);
            filler();
        end
        iFirOut = 16'sd256; iEn = 1'b1; iSymReady = 1'b1;
        @(negedge clk);
        iEn = 1'b0; iSymReady = 1'b0;
        check("pp_ovf", oOverflow, 0);
        check("pp_head", oSymbol, 3);
        iSymReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_drain_%0d", i), oSymbol, oexp[i+1]);
            @(negedge clk);
        end
        iSymReady = 1'b0;
        check("pp_empty", oSymValid, 0);
        repeat (18) @(negedge clk);
        filler();

        for (int i = 0; i < 3; i++) begin
            strobe(1000);
            filler();
        end
        check("q3_valid", oSymValid, 1);
        iRsn = 1'b0;
        @(negedge clk);
        check("mrst_valid", oSymValid, 0);
        check("mrst_sym",   oSymbol,   0);
        check("mrst_ovf",   oOverflow, 0);
        check("mrst_busy",  oBusy,     0);
        iRsn = 1'b1; iSlicerEn = 1'b0;
        strobe(1000);
        check("post_rst_idle", oBusy, 0);
        check("post_rst_empty", oSymValid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
